// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_if
//  Purpose  : Bundle between the multi-cycle sequencer and the MIPS-lite
//             datapath. Datapath -> controller: instruction fields, ALU zero
//             flag and memory ready handshakes. Controller -> datapath:
//             write strobes, mux selects, instruction-done and trap status.
//  Modports : master = controller side, slave = datapath side
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic       IMReady;
  logic       DMReady;
  logic       PCWr;
  logic       IRWr;
  logic       nPC_sel;
  logic       Jump;
  logic       RegWr;
  logic       RegDst;
  logic [1:0] ExtOp;
  logic       ALUSrc;
  logic [2:0] ALUctr;
  logic       MemRd;
  logic       MemWr;
  logic       MemtoReg;
  logic       InstrDone;
  logic       Illegal;

  modport master (
    input  opcode, funct, Zero, IMReady, DMReady,
    output PCWr, IRWr, nPC_sel, Jump, RegWr, RegDst, ExtOp, ALUSrc, ALUctr,
           MemRd, MemWr, MemtoReg, InstrDone, Illegal
  );

  modport slave (
    output opcode, funct, Zero, IMReady, DMReady,
    input  PCWr, IRWr, nPC_sel, Jump, RegWr, RegDst, ExtOp, ALUSrc, ALUctr,
           MemRd, MemWr, MemtoReg, InstrDone, Illegal
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multi-cycle sequencing FSM for the MIPS-lite datapath. Steps
//             each instruction through FETCH/DECODE/EXEC/MEM/WB, issuing
//             one-cycle write strobes and holding mux selects, and stalls on
//             the instruction/data memory ready handshakes.
//  Ports    : Clk    - clock, rising edge
//             Reset  - synchronous, active-low reset
//             bus    - multicycle_ctrl_if.master (fields, flags, strobes,
//                      selects, InstrDone, Illegal)
//  Params   : TRAP_HALT - 1: illegal opcode traps until reset,
//                         0: illegal opcode retires as a NOP
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
  parameter bit TRAP_HALT = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  multicycle_ctrl_if.master bus
);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_lui   = 6'b001111;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_fn_addu  = 6'b100001;
  localparam logic [5:0] c_fn_subu  = 6'b100011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    I_ILL, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J
  } instr_t;

  function automatic instr_t decode(input logic [5:0] op, input logic [5:0] fn);
    instr_t r;
    r = I_ILL;
    case (op)
      c_op_rtype: begin
        if (fn == c_fn_addu)      r = I_ADDU;
        else if (fn == c_fn_subu) r = I_SUBU;
        else                      r = I_ILL;
      end
      c_op_ori: r = I_ORI;
      c_op_lui: r = I_LUI;
      c_op_lw:  r = I_LW;
      c_op_sw:  r = I_SW;
      c_op_beq: r = I_BEQ;
      c_op_j:   r = I_J;
      default:  r = I_ILL;
    endcase
    return r;
  endfunction

  state_t state_q, state_d;
  instr_t cls_q, cls_d;   // decoded instruction, captured in DECODE

  instr_t     dec_cls;
  instr_t     sel_cls;
  logic       sel_en;
  logic       pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, instr_done, illegal;
  logic       npc_sel, jump, reg_dst, alu_src, mem_to_reg;
  logic [1:0] ext_op;
  logic [2:0] alu_ctr;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      cls_q   <= I_ILL;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Sequencing and strobes. Strobes depend on the ready inputs in the same
  // cycle so that a ready-high memory costs no extra cycles.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    dec_cls    = decode(bus.opcode, bus.funct);
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.IMReady) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == I_J) begin
          pc_wr      = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (dec_cls == I_ILL) begin
          if (TRAP_HALT) begin
            state_d = S_TRAP;
          end else begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls_q == I_BEQ) begin
          pc_wr      = bus.Zero;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (cls_q == I_LW || cls_q == I_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // A single request is held until the memory reports completion.
        if (cls_q == I_LW) begin
          mem_rd = 1'b1;
          if (bus.DMReady) state_d = S_WB;
        end else begin
          mem_wr = 1'b1;
          if (bus.DMReady) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Selects are live from DECODE to the end of the instruction. In DECODE the
  // instruction fields come straight from the IR; afterwards from cls_q.
  always_comb begin
    sel_cls    = (state_q == S_DECODE) ? dec_cls : cls_q;
    sel_en     = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                 (state_q == S_MEM)    || (state_q == S_WB);
    npc_sel    = 1'b0;
    jump       = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    ext_op     = 2'b00;
    alu_ctr    = 3'b000;
    if (sel_en) begin
      case (sel_cls)
        I_ADDU: reg_dst = 1'b1;
        I_SUBU: begin reg_dst = 1'b1; alu_ctr = 3'b001; end
        I_ORI:  begin alu_ctr = 3'b010; alu_src = 1'b1; end
        I_LUI:  begin alu_ctr = 3'b010; alu_src = 1'b1; ext_op = 2'b10; end
        I_LW:   begin alu_src = 1'b1; ext_op = 2'b01; mem_to_reg = 1'b1; end
        I_SW:   begin alu_src = 1'b1; ext_op = 2'b01; end
        I_BEQ:  begin alu_ctr = 3'b001; ext_op = 2'b01; npc_sel = 1'b1; end
        I_J:    jump = 1'b1;
        default: ;
      endcase
    end
  end

  // Everything is forced low during reset so a half-finished access is dropped.
  assign bus.PCWr      = Reset & pc_wr;
  assign bus.IRWr      = Reset & ir_wr;
  assign bus.nPC_sel   = Reset & npc_sel;
  assign bus.Jump      = Reset & jump;
  assign bus.RegWr     = Reset & reg_wr;
  assign bus.RegDst    = Reset & reg_dst;
  assign bus.ExtOp     = Reset ? ext_op  : 2'b00;
  assign bus.ALUSrc    = Reset & alu_src;
  assign bus.ALUctr    = Reset ? alu_ctr : 3'b000;
  assign bus.MemRd     = Reset & mem_rd;
  assign bus.MemWr     = Reset & mem_wr;
  assign bus.MemtoReg  = Reset & mem_to_reg;
  assign bus.InstrDone = Reset & instr_done;
  assign bus.Illegal   = Reset & illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Directed self-checking bench for multicycle_ctrl. Two copies
//             share one stimulus stream: TRAP_HALT=1 and TRAP_HALT=0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

  // Output vector layout:
  // {PCWr,IRWr,nPC_sel,Jump,RegWr,RegDst,ExtOp[1:0],ALUSrc,ALUctr[2:0],
  //  MemRd,MemWr,MemtoReg,InstrDone,Illegal}
  localparam logic [16:0] PCW   = 17'h10000;
  localparam logic [16:0] IRW   = 17'h08000;
  localparam logic [16:0] NPC   = 17'h04000;
  localparam logic [16:0] JMP   = 17'h02000;
  localparam logic [16:0] RGW   = 17'h01000;
  localparam logic [16:0] RDST  = 17'h00800;
  localparam logic [16:0] EXT_S = 17'h00200;
  localparam logic [16:0] EXT_L = 17'h00400;
  localparam logic [16:0] ASRC  = 17'h00100;
  localparam logic [16:0] SUB   = 17'h00020;
  localparam logic [16:0] ORR   = 17'h00040;
  localparam logic [16:0] MRD   = 17'h00010;
  localparam logic [16:0] MWR   = 17'h00008;
  localparam logic [16:0] M2R   = 17'h00004;
  localparam logic [16:0] DONE  = 17'h00002;
  localparam logic [16:0] ILL   = 17'h00001;
  localparam logic [16:0] NONE  = 17'h00000;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100001;
  localparam logic [5:0] FN_SUB = 6'b100011;

  localparam logic [16:0] SEL_LW  = ASRC | EXT_S | M2R;
  localparam logic [16:0] SEL_SW  = ASRC | EXT_S;
  localparam logic [16:0] SEL_BEQ = NPC | SUB | EXT_S;
  localparam logic [16:0] SEL_ORI = ORR | ASRC;
  localparam logic [16:0] SEL_LUI = ORR | ASRC | EXT_L;
  localparam logic [16:0] SEL_SUB = RDST | SUB;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  multicycle_ctrl_if bus_h ();
  multicycle_ctrl_if bus_n ();

  assign bus_n.opcode  = bus_h.opcode;
  assign bus_n.funct   = bus_h.funct;
  assign bus_n.Zero    = bus_h.Zero;
  assign bus_n.IMReady = bus_h.IMReady;
  assign bus_n.DMReady = bus_h.DMReady;

  multicycle_ctrl #(.TRAP_HALT(1'b1)) dut_h (.Clk(Clk), .Reset(Reset), .bus(bus_h));
  multicycle_ctrl #(.TRAP_HALT(1'b0)) dut_n (.Clk(Clk), .Reset(Reset), .bus(bus_n));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [16:0] obs_h, obs_n;
  assign obs_h = {bus_h.PCWr, bus_h.IRWr, bus_h.nPC_sel, bus_h.Jump, bus_h.RegWr,
                  bus_h.RegDst, bus_h.ExtOp, bus_h.ALUSrc, bus_h.ALUctr, bus_h.MemRd,
                  bus_h.MemWr, bus_h.MemtoReg, bus_h.InstrDone, bus_h.Illegal};
  assign obs_n = {bus_n.PCWr, bus_n.IRWr, bus_n.nPC_sel, bus_n.Jump, bus_n.RegWr,
                  bus_n.RegDst, bus_n.ExtOp, bus_n.ALUSrc, bus_n.ALUctr, bus_n.MemRd,
                  bus_n.MemWr, bus_n.MemtoReg, bus_n.InstrDone, bus_n.Illegal};

  // One clock cycle: drive inputs after the falling edge, check mid-low-phase.
  task automatic stepx(input string tag, input logic rst, input logic [5:0] op,
                       input logic [5:0] fn, input logic z, input logic imr,
                       input logic dmr, input logic [16:0] eh, input logic [16:0] en);
    @(negedge Clk);
    Reset         = rst;
    bus_h.opcode  = op;
    bus_h.funct   = fn;
    bus_h.Zero    = z;
    bus_h.IMReady = imr;
    bus_h.DMReady = dmr;
    #1;
    checks++;
    assert (obs_h === eh) else begin
      errors++;
      $error("FAIL %s halt: observed %b expected %b", tag, obs_h, eh);
    end
    checks++;
    assert (obs_n === en) else begin
      errors++;
      $error("FAIL %s nop: observed %b expected %b", tag, obs_n, en);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input logic imr,
                      input logic dmr, input logic [16:0] e);
    stepx(tag, rst, op, fn, z, imr, dmr, e, e);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    Reset         = 1'b0;
    bus_h.opcode  = 6'd0;
    bus_h.funct   = 6'd0;
    bus_h.Zero    = 1'b0;
    bus_h.IMReady = 1'b0;
    bus_h.DMReady = 1'b0;

    // Reset state
    step("rst0", 0, OP_R, FN_ADD, 0, 1, 1, NONE);
    step("rst1", 0, OP_R, FN_ADD, 0, 1, 1, NONE);

    // addu, zero wait
    step("addu_f", 1, OP_R, FN_ADD, 0, 1, 1, PCW | IRW);
    step("addu_d", 1, OP_R, FN_ADD, 0, 1, 1, RDST);
    step("addu_e", 1, OP_R, FN_ADD, 0, 1, 1, RDST);
    step("addu_w", 1, OP_R, FN_ADD, 0, 1, 1, RGW | RDST | DONE);

    // IM stall, then lw with DMReady low for 3 cycles
    step("im_stall", 1, OP_LW, 6'd0, 0, 0, 0, NONE);
    step("lw_f",  1, OP_LW, 6'd0, 0, 1, 0, PCW | IRW);
    step("lw_d",  1, OP_LW, 6'd0, 0, 1, 0, SEL_LW);
    step("lw_e",  1, OP_LW, 6'd0, 0, 1, 0, SEL_LW);
    step("lw_m0", 1, OP_LW, 6'd0, 0, 1, 0, SEL_LW | MRD);
    step("lw_m1", 1, OP_LW, 6'd0, 0, 1, 0, SEL_LW | MRD);
    step("lw_m2", 1, OP_LW, 6'd0, 0, 1, 0, SEL_LW | MRD);
    step("lw_m3", 1, OP_LW, 6'd0, 0, 1, 1, SEL_LW | MRD);
    step("lw_w",  1, OP_LW, 6'd0, 0, 1, 1, SEL_LW | RGW | DONE);

    // beq taken then not taken
    step("beq1_f", 1, OP_BEQ, 6'd0, 1, 1, 1, PCW | IRW);
    step("beq1_d", 1, OP_BEQ, 6'd0, 1, 1, 1, SEL_BEQ);
    step("beq1_e", 1, OP_BEQ, 6'd0, 1, 1, 1, SEL_BEQ | PCW | DONE);
    step("beq0_f", 1, OP_BEQ, 6'd0, 0, 1, 1, PCW | IRW);
    step("beq0_d", 1, OP_BEQ, 6'd0, 0, 1, 1, SEL_BEQ);
    step("beq0_e", 1, OP_BEQ, 6'd0, 0, 1, 1, SEL_BEQ | DONE);

    // j, then ori fetched on cycle 3
    step("j_f",   1, OP_J, 6'd0, 0, 1, 1, PCW | IRW);
    step("j_d",   1, OP_J, 6'd0, 0, 1, 1, JMP | PCW | DONE);
    step("ori_f", 1, OP_ORI, 6'd0, 0, 1, 1, PCW | IRW);
    step("ori_d", 1, OP_ORI, 6'd0, 0, 1, 1, SEL_ORI);
    step("ori_e", 1, OP_ORI, 6'd0, 0, 1, 1, SEL_ORI);
    step("ori_w", 1, OP_ORI, 6'd0, 0, 1, 1, SEL_ORI | RGW | DONE);

    // lui and subu
    step("lui_f", 1, OP_LUI, 6'd0, 0, 1, 1, PCW | IRW);
    step("lui_d", 1, OP_LUI, 6'd0, 0, 1, 1, SEL_LUI);
    step("lui_e", 1, OP_LUI, 6'd0, 0, 1, 1, SEL_LUI);
    step("lui_w", 1, OP_LUI, 6'd0, 0, 1, 1, SEL_LUI | RGW | DONE);
    step("sub_f", 1, OP_R, FN_SUB, 0, 1, 1, PCW | IRW);
    step("sub_d", 1, OP_R, FN_SUB, 0, 1, 1, SEL_SUB);
    step("sub_e", 1, OP_R, FN_SUB, 0, 1, 1, SEL_SUB);
    step("sub_w", 1, OP_R, FN_SUB, 0, 1, 1, SEL_SUB | RGW | DONE);

    // sw aborted by reset in MEM: no write, back in FETCH afterwards
    step("swa_f",  1, OP_SW, 6'd0, 0, 1, 0, PCW | IRW);
    step("swa_d",  1, OP_SW, 6'd0, 0, 1, 0, SEL_SW);
    step("swa_e",  1, OP_SW, 6'd0, 0, 1, 0, SEL_SW);
    step("swa_m",  1, OP_SW, 6'd0, 0, 1, 0, SEL_SW | MWR);
    step("swa_r0", 0, OP_SW, 6'd0, 0, 1, 0, NONE);
    step("swa_r1", 0, OP_SW, 6'd0, 0, 1, 0, NONE);
    step("swa_fh", 1, OP_SW, 6'd0, 0, 0, 0, NONE);

    // sw, zero wait
    step("sw_f", 1, OP_SW, 6'd0, 0, 1, 1, PCW | IRW);
    step("sw_d", 1, OP_SW, 6'd0, 0, 1, 1, SEL_SW);
    step("sw_e", 1, OP_SW, 6'd0, 0, 1, 1, SEL_SW);
    step("sw_m", 1, OP_SW, 6'd0, 0, 1, 1, SEL_SW | MWR | DONE);

    // unknown funct and illegal opcode behave the same way
    step("badfn_f", 1, OP_R, 6'b000000, 0, 1, 1, PCW | IRW);
    stepx("badfn_d", 1, OP_R, 6'b000000, 0, 1, 1, NONE, DONE);
    stepx("trap0",   1, OP_BAD, 6'd0, 0, 1, 1, ILL, PCW | IRW);
    stepx("trap1",   1, OP_BAD, 6'd0, 0, 1, 1, ILL, DONE);
    stepx("trap2",   1, OP_BAD, 6'd0, 0, 1, 1, ILL, PCW | IRW);

    // reset clears the trap
    step("trst", 0, OP_ORI, 6'd0, 0, 1, 1, NONE);
    step("trst_f", 1, OP_ORI, 6'd0, 0, 1, 1, PCW | IRW);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
